// File: rtl/seq_detect_prog.sv
// Programmable Moore serial-sequence detector with tick-paced sampling and a
// saturating match counter. Pattern, length and overlap mode are latched on entry to RUN.
module seq_detect_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned DIV     = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               w,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  input  logic               clear_cnt,
  output logic               z,
  output logic               tick,
  output logic [CNT_W-1:0]   match_count
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  // Only MAX_LEN-1 bits are kept; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [DivW-1:0]    div_q, div_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_eff;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               tick_run;
  logic               match;

  always_comb begin
    if (len == '0) begin
      len_eff = LEN_W'(1);
    end else if (len > LEN_W'(MAX_LEN)) begin
      len_eff = LEN_W'(MAX_LEN);
    end else begin
      len_eff = len;
    end
  end

  assign tick     = (state_q == StRun) && (div_q == DivLast);
  assign tick_run = tick && en;
  assign hist_nxt = {hist_q, w};
  assign mask     = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_q);
  assign fill_inc = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
  assign match    = tick_run && (fill_inc == len_q) && ((hist_nxt & mask) == (pat_q & mask));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    div_d   = div_q;
    z_d     = z_q;
    unique case (state_q)
      StIdle: begin
        hist_d = '0;
        fill_d = '0;
        div_d  = '0;
        z_d    = 1'b0;
        if (en) begin
          state_d = StRun;
          pat_d   = pattern;
          len_d   = len_eff;
          ovl_d   = overlap;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
          hist_d  = '0;
          fill_d  = '0;
          div_d   = '0;
          z_d     = 1'b0;
        end else begin
          div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
          if (tick_run) begin
            hist_d = hist_nxt[MAX_LEN-2:0];
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
            z_d    = match;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_cnt) begin
      cnt_d = CNT_W'(match);
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      div_q   <= '0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      div_q   <= div_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign z           = z_q;
  assign match_count = cnt_q;

endmodule
